// File: rtl/fperm_sched_pkg.sv
// Shared types for the fperm issue scheduler: op encoding, kind enum, legal latencies.
package fperm_sched_pkg;

    typedef enum logic [1:0] {
        KIND_PERM = 2'b00,
        KIND_DIV  = 2'b01,
        KIND_SQRT = 2'b10,
        KIND_BAD  = 2'b11
    } kind_e;

    typedef struct packed {
        kind_e kind;
        logic  dup_sngl;
        logic  swp_sngl;
        logic  copy_a;
    } op_t;

    localparam int LAT_C0 = 1;
    localparam int LAT_C1 = 3;

endpackage

// File: rtl/fperm_rr_pick.sv
// Combinational one-hot pick: starved ports (lowest index) first, else round-robin from ptr.
module fperm_rr_pick #(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] elig,
    input  logic [NREQ-1:0] starved,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic            starve_win
);

    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    // Loops run from the far end so the last hit (highest priority) wins.
    always_comb begin
        gnt        = '0;
        starve_win = 1'b0;
        if (|(elig & starved)) begin
            starve_win = 1'b1;
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (elig[i] && starved[i]) begin
                    gnt = ONE << i;
                end
            end
        end else begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (elig[(int'(ptr) + k) % NREQ]) begin
                    gnt = ONE << ((int'(ptr) + k) % NREQ);
                end
            end
        end
    end

endmodule

// File: rtl/fperm_sched.sv
// Issue scheduler for the shared fperm unit: arbitration, strobe register, result tag pipe.
// Optional perf counters are built when FPERM_SCHED_PERF_EN is defined.
module fperm_sched
    import fperm_sched_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int LAT    = 1,
    parameter int TAGW   = 9,
    parameter int STARVE = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_vld,
    input  logic [NREQ*5-1:0]    req_op,
    input  logic [NREQ*TAGW-1:0] req_tag,
    output logic [NREQ-1:0]      req_gnt,
    input  logic [2:0]           bus_busy,
    input  logic                 flush,
    output logic [NREQ-1:0]      sel,
    output logic                 en,
    output logic                 copyA,
    output logic                 swpSngl,
    output logic                 dupSngl,
    output logic                 is_div,
    output logic                 is_sqrt,
`ifdef FPERM_SCHED_PERF_EN
    output logic [15:0]          perf_gnt,
    output logic [15:0]          perf_busblk,
    output logic [15:0]          perf_starve,
`endif
    output logic                 res_vld,
    output logic [TAGW-1:0]      res_tag
);

    localparam int DEPTH = (LAT == LAT_C1) ? LAT_C1 : LAT_C0;
    localparam int PW    = (NREQ > 2) ? 2 : 1;
    localparam int SW    = $clog2(STARVE + 1);

    op_t [NREQ-1:0]             ops;
    logic [NREQ-1:0]            legal, elig, starved, gnt;
    logic                       starve_win;
    logic                       busy_slot;
    logic                       unused_bus;

    logic [PW-1:0]              ptr_q, ptr_d;
    logic [NREQ-1:0][SW-1:0]    wait_q, wait_d;
    logic [NREQ-1:0]            sel_q, sel_d;
    logic                       en_q, en_d;
    logic [4:0]                 strb_q, strb_d;
    logic [TAGW-1:0]            tag_q, tag_d;
    logic [DEPTH-1:0]           pvld_q, pvld_d;
    logic [DEPTH-1:0][TAGW-1:0] ptag_q, ptag_d;

    // Only the slot our result will land in matters; other bits belong to other latencies.
    assign busy_slot  = bus_busy[DEPTH-1];
    assign unused_bus = ^bus_busy;

    always_comb begin
        ops     = '0;
        legal   = '0;
        elig    = '0;
        starved = '0;
        for (int i = 0; i < NREQ; i++) begin
            ops[i]     = op_t'(req_op[i*5 +: 5]);
            legal[i]   = req_vld[i] && (ops[i].kind != KIND_BAD);
            elig[i]    = legal[i] && !busy_slot && !flush && !rst;
            starved[i] = (wait_q[i] == SW'(STARVE));
        end
    end

    fperm_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .elig       (elig),
        .starved    (starved),
        .ptr        (ptr_q),
        .gnt        (gnt),
        .starve_win (starve_win)
    );

    assign req_gnt = gnt;

    always_comb begin
        ptr_d  = ptr_q;
        wait_d = wait_q;
        sel_d  = gnt;
        en_d   = |gnt;
        strb_d = '0;
        tag_d  = '0;
        pvld_d = '0;
        ptag_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                strb_d = {ops[i].copy_a,
                          ops[i].swp_sngl,
                          ops[i].dup_sngl && (ops[i].kind == KIND_PERM),
                          ops[i].kind == KIND_DIV,
                          ops[i].kind == KIND_SQRT};
                tag_d  = req_tag[i*TAGW +: TAGW];
                ptr_d  = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
        if (!flush) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_vld[i] || gnt[i]) begin
                    wait_d[i] = '0;
                end else if (!starved[i]) begin
                    wait_d[i] = wait_q[i] + 1'b1;
                end
            end
        end
        // Flush kills the op currently at en as well as everything already in the pipe.
        pvld_d[0] = en_q && !flush;
        ptag_d[0] = flush ? '0 : tag_q;
        for (int s = 1; s < DEPTH; s++) begin
            pvld_d[s] = pvld_q[s-1] && !flush;
            ptag_d[s] = flush ? '0 : ptag_q[s-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= '0;
            wait_q <= '0;
            sel_q  <= '0;
            en_q   <= 1'b0;
            strb_q <= '0;
            tag_q  <= '0;
            pvld_q <= '0;
            ptag_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            wait_q <= wait_d;
            sel_q  <= sel_d;
            en_q   <= en_d;
            strb_q <= strb_d;
            tag_q  <= tag_d;
            pvld_q <= pvld_d;
            ptag_q <= ptag_d;
        end
    end

    assign sel     = sel_q;
    assign en      = en_q;
    assign copyA   = strb_q[4];
    assign swpSngl = strb_q[3];
    assign dupSngl = strb_q[2];
    assign is_div  = strb_q[1];
    assign is_sqrt = strb_q[0];
    assign res_vld = pvld_q[DEPTH-1];
    assign res_tag = ptag_q[DEPTH-1];

`ifdef FPERM_SCHED_PERF_EN
    logic [15:0] pgnt_q, pgnt_d, pblk_q, pblk_d, pstv_q, pstv_d;

    always_comb begin
        pgnt_d = pgnt_q + 16'(|gnt);
        pblk_d = pblk_q + 16'((|legal) && busy_slot);
        pstv_d = pstv_q + 16'(starve_win && (|gnt));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pgnt_q <= '0;
            pblk_q <= '0;
            pstv_q <= '0;
        end else begin
            pgnt_q <= pgnt_d;
            pblk_q <= pblk_d;
            pstv_q <= pstv_d;
        end
    end

    assign perf_gnt    = pgnt_q;
    assign perf_busblk = pblk_q;
    assign perf_starve = pstv_q;
`else
    logic unused_perf;
    assign unused_perf = starve_win;
`endif

endmodule

// File: tb/tb_fperm_sched.sv
// Bench for fperm_sched: two instances (LAT=1/STARVE=2 and LAT=3/STARVE=7) against a grant-log model.
module tb_fperm_sched;

    localparam int MAXC = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_vld;
    logic [14:0] req_op;
    logic [26:0] req_tag;
    logic [2:0]  bus_busy;
    logic        flush;

    logic [1:0][2:0] gnt_w, sel_w;
    logic [1:0]      en_w, ca_w, sw_w, du_w, dv_w, sq_w, rv_w;
    logic [1:0][8:0] rt_w;
`ifdef FPERM_SCHED_PERF_EN
    logic [1:0][15:0] pg_w, pb_w, ps_w;
`endif

    always #5 clk = ~clk;

    fperm_sched #(.NREQ(3), .LAT(1), .TAGW(9), .STARVE(2)) u_dut_a (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_op(req_op), .req_tag(req_tag),
        .req_gnt(gnt_w[0]), .bus_busy(bus_busy), .flush(flush), .sel(sel_w[0]),
        .en(en_w[0]), .copyA(ca_w[0]), .swpSngl(sw_w[0]), .dupSngl(du_w[0]),
        .is_div(dv_w[0]), .is_sqrt(sq_w[0]),
`ifdef FPERM_SCHED_PERF_EN
        .perf_gnt(pg_w[0]), .perf_busblk(pb_w[0]), .perf_starve(ps_w[0]),
`endif
        .res_vld(rv_w[0]), .res_tag(rt_w[0])
    );

    fperm_sched #(.NREQ(3), .LAT(3), .TAGW(9), .STARVE(7)) u_dut_b (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_op(req_op), .req_tag(req_tag),
        .req_gnt(gnt_w[1]), .bus_busy(bus_busy), .flush(flush), .sel(sel_w[1]),
        .en(en_w[1]), .copyA(ca_w[1]), .swpSngl(sw_w[1]), .dupSngl(du_w[1]),
        .is_div(dv_w[1]), .is_sqrt(sq_w[1]),
`ifdef FPERM_SCHED_PERF_EN
        .perf_gnt(pg_w[1]), .perf_busblk(pb_w[1]), .perf_starve(ps_w[1]),
`endif
        .res_vld(rv_w[1]), .res_tag(rt_w[1])
    );

    // Grant log per instance: which port was granted in each cycle, its op/tag, and whether it still lives.
    int         gp     [2][MAXC];
    logic [4:0] gop    [2][MAXC];
    logic [8:0] gtag   [2][MAXC];
    bit         galive [2][MAXC];
    int         mptr   [2];
    int         mwait  [2][3];
    int         cyc;
    int         total;
    int         bad;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int starve_of(input int k);
        return (k == 0) ? 2 : 7;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_check(input int k);
        int         lat, stv, g, pick, r;
        logic [2:0] elig, exp_gnt, exp_sel;
        logic [4:0] op, exp_strb;
        logic       exp_en, exp_rv;
        logic [8:0] exp_rt;
        lat      = lat_of(k);
        stv      = starve_of(k);
        exp_gnt  = '0;
        exp_sel  = '0;
        exp_strb = '0;
        exp_en   = 1'b0;
        exp_rv   = 1'b0;
        exp_rt   = '0;
        pick     = -1;
        if (!rst) begin
            g = (cyc >= 1) ? gp[k][cyc-1] : -1;
            if (g >= 0) begin
                op       = gop[k][cyc-1];
                exp_en   = 1'b1;
                exp_sel  = 3'(1 << g);
                exp_strb = {op[0], op[1], op[2] && (op[4:3] == 2'b00),
                            op[4:3] == 2'b01, op[4:3] == 2'b10};
            end
            r = cyc - 1 - lat;
            if (r >= 0 && gp[k][r] >= 0 && galive[k][r]) begin
                exp_rv = 1'b1;
                exp_rt = gtag[k][r];
            end
            for (int i = 0; i < 3; i++) begin
                elig[i] = req_vld[i] && (req_op[i*5+3 +: 2] != 2'b11) && !bus_busy[lat-1] && !flush;
            end
            for (int i = 0; i < 3; i++) begin
                if (pick < 0 && elig[i] && mwait[k][i] == stv) pick = i;
            end
            for (int d = 0; d < 3; d++) begin
                if (pick < 0 && elig[(mptr[k] + d) % 3]) pick = (mptr[k] + d) % 3;
            end
            if (pick >= 0) exp_gnt = 3'(1 << pick);
        end

        chk($sformatf("gnt_%0d", k), 32'(gnt_w[k]), 32'(exp_gnt));
        chk($sformatf("issue_%0d", k),
            32'({en_w[k], ca_w[k], sw_w[k], du_w[k], dv_w[k], sq_w[k], sel_w[k]}),
            32'({exp_en, exp_strb, exp_sel}));
        chk($sformatf("result_%0d", k), 32'({rv_w[k], rt_w[k]}), 32'({exp_rv, exp_rt}));

        if (rst) begin
            mptr[k] = 0;
            for (int i = 0; i < 3; i++) mwait[k][i] = 0;
            for (int j = 0; j <= cyc; j++) gp[k][j] = -1;
        end else begin
            gp[k][cyc] = pick;
            if (pick >= 0) begin
                gop[k][cyc]    = req_op[pick*5 +: 5];
                gtag[k][cyc]   = req_tag[pick*9 +: 9];
                galive[k][cyc] = 1'b1;
            end
            if (flush) begin
                for (int j = cyc - lat; j < cyc; j++) begin
                    if (j >= 0) galive[k][j] = 1'b0;
                end
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (!req_vld[i] || i == pick) mwait[k][i] = 0;
                    else if (mwait[k][i] < stv)   mwait[k][i]++;
                end
                if (pick >= 0) mptr[k] = (pick + 1) % 3;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_check(0);
        model_check(1);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] v, input logic [14:0] op, input logic [26:0] tg,
                         input logic [2:0] bb, input logic fl);
        req_vld  = v;
        req_op   = op;
        req_tag  = tg;
        bus_busy = bb;
        flush    = fl;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        for (int k = 0; k < 2; k++) begin
            mptr[k] = 0;
            for (int i = 0; i < 3; i++) mwait[k][i] = 0;
            for (int j = 0; j < MAXC; j++) begin
                gp[k][j]     = -1;
                galive[k][j] = 1'b0;
                gop[k][j]    = '0;
                gtag[k][j]   = '0;
            end
        end

        rst = 1'b1;
        drive(3'b000, '0, '0, 3'b000, 1'b0);
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();

        // single perm copyA|swpSngl on port1
        drive(3'b010, {5'b0, 5'b00011, 5'b0}, {9'h0, 9'h055, 9'h0}, 3'b000, 1'b0);
        step();
        drive(3'b000, '0, '0, 3'b000, 1'b0);
        repeat (5) step();

        // all three ports held, mixed kinds
        drive(3'b111, {5'b10001, 5'b01110, 5'b00111}, {9'h1c2, 9'h0b1, 9'h0a0}, 3'b000, 1'b0);
        repeat (6) step();
        drive(3'b000, '0, '0, 3'b000, 1'b0);
        repeat (4) step();

        // bus conflict on slot 3 (blocks the LAT=3 instance only)
        drive(3'b001, {10'b0, 5'b00100}, {18'h0, 9'h1aa}, 3'b100, 1'b0);
        repeat (4) step();
        drive(3'b001, {10'b0, 5'b00100}, {18'h0, 9'h1ab}, 3'b000, 1'b0);
        step();
        drive(3'b000, '0, '0, 3'b000, 1'b0);
        repeat (4) step();

        // starvation: port2 accumulates waits while slot 1 is busy, then competes
        drive(3'b100, {5'b00001, 10'b0}, {9'h0c3, 18'h0}, 3'b001, 1'b0);
        repeat (2) step();
        drive(3'b111, {5'b00001, 5'b00010, 5'b00100}, {9'h0c3, 9'h0c2, 9'h0c1}, 3'b000, 1'b0);
        repeat (4) step();
        drive(3'b000, '0, '0, 3'b000, 1'b0);
        repeat (4) step();

        // flush one cycle before the LAT=3 instance's first result
        drive(3'b001, {10'b0, 5'b00001}, {18'h0, 9'h011}, 3'b000, 1'b0);
        step();
        drive(3'b001, {10'b0, 5'b00010}, {18'h0, 9'h022}, 3'b000, 1'b0);
        step();
        drive(3'b000, '0, '0, 3'b000, 1'b0);
        step();
        drive(3'b010, {5'b0, 5'b00001, 5'b0}, {9'h0, 9'h033, 9'h0}, 3'b000, 1'b1);
        step();
        drive(3'b010, {5'b0, 5'b00001, 5'b0}, {9'h0, 9'h033, 9'h0}, 3'b000, 1'b0);
        step();
        drive(3'b000, '0, '0, 3'b000, 1'b0);
        repeat (6) step();

        // illegal kind is never granted
        drive(3'b010, {5'b0, 5'b11111, 5'b0}, {9'h0, 9'h1ff, 9'h0}, 3'b000, 1'b0);
        repeat (20) step();
        drive(3'b000, '0, '0, 3'b000, 1'b0);
        step();

        // reset while ops are in flight
        drive(3'b001, {10'b0, 5'b01000}, {18'h0, 9'h144}, 3'b000, 1'b0);
        step();
        step();
        rst = 1'b1;
        drive(3'b000, '0, '0, 3'b000, 1'b0);
        step();
        rst = 1'b0;
        repeat (6) step();

        for (int n = 0; n < 500; n++) begin
            rst      = ($urandom_range(0, 149) == 0);
            req_vld  = 3'($urandom);
            req_op   = 15'($urandom);
            req_tag  = 27'($urandom);
            bus_busy = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            flush    = ($urandom_range(0, 19) == 0);
            step();
        end
        rst = 1'b0;
        drive(3'b000, '0, '0, 3'b000, 1'b0);
        repeat (6) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
